// File: rtl/mcycle_engine.sv
// mcycle_engine: iterative 32-bit unsigned multiply / divide unit.
//   Multiply: radix-2 shift-and-add, full 64-bit product.
//   Divide:   restoring division, 33-bit partial remainder, MSB-first.
//   Each operation takes 32 iterations after acceptance, then a one-cycle
//   DONE state that pulses Done.
// Ports:
//   CLK, RESETn         clock, asynchronous active-low reset
//   Start, MCycleOp     request and op select (0 = mul, 1 = div)
//   Operand1, Operand2  multiplicand/dividend, multiplier/divisor
//   Result1, Result2    product lo / quotient, product hi / remainder
//   Busy                combinational stall request
//   Done                registered one-cycle completion pulse
module mcycle_engine (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        Start,
  input  logic        MCycleOp,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  output logic [31:0] Result1,
  output logic [31:0] Result2,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {S_IDLE, S_COMP, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        op;
  logic [31:0] mcand;
  logic [63:0] acc;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [32:0] rem;

  logic        accept, last;
  logic [32:0] mul_sum;
  logic [63:0] acc_nxt;
  logic [32:0] rem_sh, rem_diff, rem_nxt;
  logic        div_ok;
  logic [31:0] quo_nxt;

  assign accept = (state == S_IDLE) && Start;
  assign last   = (state == S_COMP) && (cnt == 5'd31);

  // Gated by RESETn so a held Start cannot raise a stall while in reset.
  assign Busy = RESETn && (accept || (state == S_COMP));

  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the 65-bit sum right.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
  assign acc_nxt = {mul_sum, acc[31:1]};

  // Divide step: shift in the next dividend bit, trial-subtract. A clear
  // sign bit means the subtraction fits. With divisor 0 every trial fits,
  // yielding quotient all-ones and remainder = dividend.
  assign rem_sh   = {rem[31:0], quo[31]};
  assign rem_diff = rem_sh - {1'b0, divisor};
  assign div_ok   = ~rem_diff[32];
  assign rem_nxt  = div_ok ? rem_diff : rem_sh;
  assign quo_nxt  = {quo[30:0], div_ok};

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (Start) state_nxt = S_COMP;
      S_COMP: if (cnt == 5'd31) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt     <= '0;
      op      <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      divisor <= '0;
      quo     <= '0;
      rem     <= '0;
      Result1 <= '0;
      Result2 <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= last;
      if (accept) begin
        cnt     <= '0;
        op      <= MCycleOp;
        mcand   <= Operand1;
        acc     <= {32'd0, Operand2};
        divisor <= Operand2;
        quo     <= Operand1;
        rem     <= '0;
      end else if (state == S_COMP) begin
        cnt <= cnt + 5'd1;
        acc <= acc_nxt;
        quo <= quo_nxt;
        rem <= rem_nxt;
      end
      // Results are taken straight from the final iteration's next values.
      if (last) begin
        Result1 <= op ? quo_nxt      : acc_nxt[31:0];
        Result2 <= op ? rem_nxt[31:0] : acc_nxt[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mcycle_engine.sv
// Directed self-checking bench for mcycle_engine.
module tb_mcycle_engine;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        Start;
  logic        MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;

  int n_cmp = 0;
  int n_bad = 0;

  mcycle_engine dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  // Launches one op (Start high for exactly cycle T), scrambles inputs
  // afterwards, and reports timing violations plus results sampled at T+33.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output int tbad, output logic [31:0] r1, output logic [31:0] r2);
    tbad = 0;
    @(posedge CLK); #1;
    MCycleOp = op; Operand1 = a; Operand2 = b; Start = 1'b1;
    #1;
    if (Busy !== 1'b1) tbad++;
    @(posedge CLK); #1;
    Start = 1'b0; Operand1 = ~a; Operand2 = ~b; MCycleOp = ~op;
    for (int i = 1; i <= 32; i++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) tbad++;
      @(posedge CLK); #1;
    end
    if (Busy !== 1'b0 || Done !== 1'b1) tbad++;
    r1 = Result1; r2 = Result2;
    @(posedge CLK); #1;
    if (Done !== 1'b0) tbad++;
  endtask

  task automatic test_reset();
    int tbad;
    RESETn = 1'b0; Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd7; Operand2 = 32'd6;
    repeat (3) @(posedge CLK);
    #2;
    n_cmp++;
    if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++;
    if (Result1 !== 32'd0 || Result2 !== 32'd0 || Done !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got r1=%h r2=%h done=%b want 0/0/0", Result1, Result2, Done);
    end
    // Release mid-cycle with Start already high: must be accepted this cycle.
    RESETn = 1'b1; #1;
    n_cmp++;
    if (Busy !== 1'b1) begin n_bad++; $display("FAIL first_accept_busy: got %b want 1", Busy); end
    @(posedge CLK); #1;
    Start = 1'b0;
    tbad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) tbad++;
      @(posedge CLK); #1;
    end
    n_cmp++;
    if (Done !== 1'b1 || Busy !== 1'b0 || tbad != 0) begin
      n_bad++; $display("FAIL first_accept_timing: got done=%b busy=%b errs=%0d want 1/0/0", Done, Busy, tbad);
    end
    n_cmp++;
    if (Result1 !== 32'h0000002A || Result2 !== 32'd0) begin
      n_bad++; $display("FAIL first_accept_mul7x6: got %h:%h want 00000000:0000002a", Result2, Result1);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_mul();
    int tbad; logic [31:0] r1, r2;
    run_op(1'b0, 32'd7, 32'd6, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'h0000002A || r2 !== 32'd0) begin
      n_bad++; $display("FAIL mul_7x6: got %h:%h errs=%0d want 00000000:0000002a errs=0", r2, r1, tbad);
    end
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'h00000001 || r2 !== 32'hFFFFFFFE) begin
      n_bad++; $display("FAIL mul_max: got %h:%h errs=%0d want fffffffe:00000001 errs=0", r2, r1, tbad);
    end
    run_op(1'b0, 32'h12345678, 32'h00000010, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'h23456780 || r2 !== 32'h00000001) begin
      n_bad++; $display("FAIL mul_shift: got %h:%h errs=%0d want 00000001:23456780 errs=0", r2, r1, tbad);
    end
  endtask

  task automatic test_div();
    int tbad; logic [31:0] r1, r2;
    run_op(1'b1, 32'd100, 32'd7, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'd14 || r2 !== 32'd2) begin
      n_bad++; $display("FAIL div_100_7: got q=%0d r=%0d errs=%0d want q=14 r=2 errs=0", r1, r2, tbad);
    end
    run_op(1'b1, 32'h80000000, 32'd1, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'h80000000 || r2 !== 32'd0) begin
      n_bad++; $display("FAIL div_msb_1: got q=%h r=%h errs=%0d want q=80000000 r=0 errs=0", r1, r2, tbad);
    end
    run_op(1'b1, 32'hFFFFFFFF, 32'h00010000, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'h0000FFFF || r2 !== 32'h0000FFFF) begin
      n_bad++; $display("FAIL div_big: got q=%h r=%h errs=%0d want q=0000ffff r=0000ffff errs=0", r1, r2, tbad);
    end
  endtask

  task automatic test_div_zero();
    int tbad; logic [31:0] r1, r2;
    run_op(1'b1, 32'h12345678, 32'd0, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'hFFFFFFFF || r2 !== 32'h12345678) begin
      n_bad++; $display("FAIL div_zero: got q=%h r=%h errs=%0d want q=ffffffff r=12345678 errs=0", r1, r2, tbad);
    end
  endtask

  task automatic test_hold();
    logic [31:0] r1, r2;
    r1 = Result1; r2 = Result2;
    Start = 1'b0; Operand1 = 32'hDEAD0001; Operand2 = 32'hBEEF0002; MCycleOp = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (Result1 !== 32'hFFFFFFFF || Result2 !== 32'h12345678 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_bad++; $display("FAIL result_hold: got q=%h r=%h busy=%b done=%b want ffffffff/12345678/0/0 (prev %h/%h)",
                        Result1, Result2, Busy, Done, r1, r2);
    end
  endtask

  // Noise during COMPUTING is ignored; Start held through DONE relaunches.
  task automatic test_back_to_back();
    int tbad, ndone;
    tbad = 0; ndone = 0;
    @(posedge CLK); #1;
    MCycleOp = 1'b0; Operand1 = 32'd5; Operand2 = 32'd5; Start = 1'b1;
    @(posedge CLK); #1;                       // T+1
    Start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i >= 4 && i <= 8) begin
        Start = 1'b1; MCycleOp = ~MCycleOp; Operand1 = Operand1 + 32'd3; Operand2 = Operand2 ^ 32'hFF;
      end else if (i == 32) begin
        Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd3; Operand2 = 32'd4;
      end else begin
        Start = 1'b0;
      end
      #1;
      if (Busy !== 1'b1) tbad++;
      if (Done === 1'b1) ndone++;
      @(posedge CLK); #1;
    end
    // T+33, Start still high
    n_cmp++;
    if (Done !== 1'b1 || Busy !== 1'b0 || tbad != 0 || ndone != 0) begin
      n_bad++; $display("FAIL b2b_done: got done=%b busy=%b errs=%0d early=%0d want 1/0/0/0", Done, Busy, tbad, ndone);
    end
    n_cmp++;
    if (Result1 !== 32'd25 || Result2 !== 32'd0) begin
      n_bad++; $display("FAIL b2b_mul5x5: got %h:%h want 00000000:00000019", Result2, Result1);
    end
    @(posedge CLK); #1;                       // T+34: IDLE with Start high
    n_cmp++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_relaunch: got busy=%b done=%b want 1/0", Busy, Done);
    end
    @(posedge CLK); #1;
    Start = 1'b0;
    tbad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (Busy !== 1'b1 || Done !== 1'b0) tbad++;
      @(posedge CLK); #1;
    end
    n_cmp++;
    if (Done !== 1'b1 || tbad != 0 || Result1 !== 32'd12 || Result2 !== 32'd0) begin
      n_bad++; $display("FAIL b2b_second: got done=%b errs=%0d %h:%h want 1/0 00000000:0000000c", Done, tbad, Result2, Result1);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    int tbad; logic [31:0] r1, r2;
    @(posedge CLK); #1;
    MCycleOp = 1'b1; Operand1 = 32'd1000; Operand2 = 32'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;                                      // T+10
    RESETn = 1'b0; Start = 1'b1;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || Result1 !== 32'd0 || Result2 !== 32'd0 || Done !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid: got busy=%b r1=%h r2=%h done=%b want 0/0/0/0", Busy, Result1, Result2, Done);
    end
    @(posedge CLK); #1;
    Start = 1'b0; RESETn = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    n_cmp++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Result1 !== 32'd0) begin
      n_bad++; $display("FAIL reset_abandon: got done=%b busy=%b r1=%h want 0/0/0", Done, Busy, Result1);
    end
    run_op(1'b1, 32'd9, 32'd3, tbad, r1, r2);
    n_cmp++;
    if (tbad != 0 || r1 !== 32'd3 || r2 !== 32'd0) begin
      n_bad++; $display("FAIL div_9_3: got q=%0d r=%0d errs=%0d want q=3 r=0 errs=0", r1, r2, tbad);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
